power_mode_ctrl: RTL and testbench

//  Multi-domain power-mode controller, successor to the single-domain ACTIVE/IDLE/SLEEP FSM.
//  One independent FSM per power domain, plus:
//   - idle-timeout counting
//   - a DEEP (rail-off) mode
//   - a rail power-up handshake with timeout

---
 rtl/power_mode_ctrl_pkg.sv | 24 ++
 rtl/power_domain_fsm.sv | 129 ++++++++++++
 rtl/power_mode_ctrl.sv | 50 +++++
 tb/tb_power_mode_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/power_mode_ctrl_pkg.sv
// Shared encodings for the multi-domain power-mode controller.
package power_pkg;

  localparam logic [1:0] MODE_ACTIVE = 2'b00;
  localparam logic [1:0] MODE_IDLE   = 2'b01;
  localparam logic [1:0] MODE_SLEEP  = 2'b10;
  localparam logic [1:0] MODE_DEEP   = 2'b11;

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_DEEP   = 3'd3,
    ST_WAKE   = 3'd4
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/power_domain_fsm.sv
// One power domain: state machine, shared cycle counter and registered
// clock-gate / power-switch / mode outputs.
module power_domain_fsm
  import power_pkg::*;
#(
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned DEEP_CYC = 64,
  parameter int unsigned WAKE_TO  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       act,
  input  logic       sleep_req,
  input  logic       pwr_ack,
  output logic [1:0] power_mode,
  output logic       clk_en,
  output logic       pwr_on,
  output logic       wake_err,
  output logic       asleep
);

  localparam int unsigned CNT_W = $clog2(max3(IDLE_CYC, DEEP_CYC, WAKE_TO) + 1);
  localparam bit          DEEP_EN = (DEEP_CYC > 0);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEEP_LAST = CNT_W'((DEEP_CYC > 0) ? DEEP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_TO - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err_nx;
  logic [1:0]       mode_d;
  logic             clk_en_d, pwr_on_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Every transition also clears the counter, so each branch that moves
  // state writes cnt_nx = '0 explicitly.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (act) begin
          cnt_nx = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        cnt_nx = '0;
        if (act)            state_nx = ST_ACTIVE;
        else if (sleep_req) state_nx = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (act) begin
          state_nx = ST_ACTIVE;
          cnt_nx   = '0;
        end else if (DEEP_EN && (cnt == DEEP_LAST)) begin
          state_nx = ST_DEEP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_DEEP: begin
        cnt_nx = '0;
        if (act) state_nx = ST_WAKE;
      end
      ST_WAKE: begin
        if (pwr_ack) begin
          state_nx = ST_ACTIVE;
          cnt_nx   = '0;
        end else if (cnt == WAKE_LAST) begin
          state_nx = ST_DEEP;
          cnt_nx   = '0;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_ACTIVE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    mode_d   = MODE_ACTIVE;
    clk_en_d = 1'b1;
    pwr_on_d = 1'b1;
    case (state)
      ST_IDLE:  mode_d = MODE_IDLE;
      ST_SLEEP: begin mode_d = MODE_SLEEP; clk_en_d = 1'b0; end
      ST_DEEP:  begin mode_d = MODE_DEEP;  clk_en_d = 1'b0; pwr_on_d = 1'b0; end
      ST_WAKE:  begin mode_d = MODE_DEEP;  clk_en_d = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      power_mode <= MODE_ACTIVE;
      clk_en     <= 1'b1;
      pwr_on     <= 1'b1;
      wake_err   <= 1'b0;
    end else begin
      power_mode <= mode_d;
      clk_en     <= clk_en_d;
      pwr_on     <= pwr_on_d;
      wake_err   <= err_nx;
    end
  end

  assign asleep = (state == ST_SLEEP) || (state == ST_DEEP);

endmodule

// File: rtl/power_mode_ctrl.sv
// Multi-domain power-mode controller: N_DOM independent domain FSMs plus
// a registered all-domains-asleep flag.
module power_mode_ctrl
  import power_pkg::*;
#(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned IDLE_CYC = 16,
  parameter int unsigned DEEP_CYC = 64,
  parameter int unsigned WAKE_TO  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_DOM-1:0]     activity,
  input  logic [N_DOM-1:0]     sleep_req,
  input  logic                 force_active,
  input  logic [N_DOM-1:0]     pwr_ack,
  output logic [2*N_DOM-1:0]   power_mode,
  output logic [N_DOM-1:0]     clk_en,
  output logic [N_DOM-1:0]     pwr_on,
  output logic [N_DOM-1:0]     wake_err,
  output logic                 all_asleep
);

  logic [N_DOM-1:0] asleep;

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    power_domain_fsm #(
      .IDLE_CYC (IDLE_CYC),
      .DEEP_CYC (DEEP_CYC),
      .WAKE_TO  (WAKE_TO)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .act        (activity[d] | force_active),
      .sleep_req  (sleep_req[d]),
      .pwr_ack    (pwr_ack[d]),
      .power_mode (power_mode[2*d+1:2*d]),
      .clk_en     (clk_en[d]),
      .pwr_on     (pwr_on[d]),
      .wake_err   (wake_err[d]),
      .asleep     (asleep[d])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_asleep <= 1'b0;
    else        all_asleep <= &asleep;
  end

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Directed self-checking bench for power_mode_ctrl (2 domains, short timeouts).
module tb_power_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] activity, sleep_req, pwr_ack;
  logic       force_active;
  logic [3:0] power_mode;
  logic [1:0] clk_en, pwr_on, wake_err;
  logic       all_asleep;

  int n_tests = 0;
  int n_fail  = 0;

  power_mode_ctrl #(
    .N_DOM    (2),
    .IDLE_CYC (4),
    .DEEP_CYC (8),
    .WAKE_TO  (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .activity     (activity),
    .sleep_req    (sleep_req),
    .force_active (force_active),
    .pwr_ack      (pwr_ack),
    .power_mode   (power_mode),
    .clk_en       (clk_en),
    .pwr_on       (pwr_on),
    .wake_err     (wake_err),
    .all_asleep   (all_asleep)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; activity = 2'b11; sleep_req = 2'b00; pwr_ack = 2'b00; force_active = 1'b0;
    #12;
    check("rst_mode",   8'(power_mode), 8'h00);
    check("rst_clk_en", 8'(clk_en),     8'h03);
    check("rst_pwr_on", 8'(pwr_on),     8'h03);
    check("rst_err",    8'(wake_err),   8'h00);
    check("rst_asleep", 8'(all_asleep), 8'h00);
    step(); rst_n = 1'b1;

    // idle timeout with an activity pulse restarting the count
    activity[0] = 1'b0; step(); step();
    activity[0] = 1'b1; step();
    activity[0] = 1'b0; step(); step(); step(); step();
    check("restart_hold", 8'(power_mode[1:0]), 8'h0);
    step();
    check("idle_mode",   8'(power_mode[1:0]), 8'h1);
    check("idle_clk_en", 8'(clk_en),          8'h3);

    // activity beats sleep_req in IDLE; then sleep_req alone
    activity[0] = 1'b1; sleep_req[0] = 1'b1; step();
    sleep_req[0] = 1'b0; step();
    check("idle_act_prio", 8'(power_mode[1:0]), 8'h0);
    activity[0] = 1'b0; repeat (4) step();
    sleep_req[0] = 1'b1; step();
    sleep_req[0] = 1'b0; step();
    check("sleep_mode",   8'(power_mode[1:0]), 8'h2);
    check("sleep_clk_en", 8'(clk_en[0]),       8'h0);
    check("sleep_pwr_on", 8'(pwr_on[0]),       8'h1);

    // SLEEP -> DEEP after 8 cycles, then wake with ack
    repeat (7) step();
    check("sleep_before_deep", 8'(power_mode[1:0]), 8'h2);
    step();
    check("deep_mode",   8'(power_mode[1:0]), 8'h3);
    check("deep_pwr_on", 8'(pwr_on[0]),       8'h0);
    activity[0] = 1'b1; step();
    activity[0] = 1'b0; step();
    check("wake_mode",   8'(power_mode[1:0]), 8'h3);
    check("wake_pwr_on", 8'(pwr_on[0]),       8'h1);
    check("wake_clk_en", 8'(clk_en[0]),       8'h0);
    step();
    pwr_ack[0] = 1'b1; step();
    pwr_ack[0] = 1'b0; activity[0] = 1'b1; step();
    check("ack_mode",   8'(power_mode[1:0]), 8'h0);
    check("ack_clk_en", 8'(clk_en[0]),       8'h1);

    // wake timeout
    activity[0] = 1'b0; repeat (4) step();
    sleep_req[0] = 1'b1; step();
    sleep_req[0] = 1'b0; repeat (8) step();
    activity[0] = 1'b1; step();
    activity[0] = 1'b0; repeat (4) step();
    check("no_early_err", 8'(wake_err), 8'h0);
    step();
    check("wake_err_pulse",   8'(wake_err),  8'h1);
    check("err_cycle_pwr_on", 8'(pwr_on[0]), 8'h1);
    step();
    check("err_one_cycle",  8'(wake_err),         8'h0);
    check("to_deep_mode",   8'(power_mode[1:0]),  8'h3);
    check("to_deep_pwr_on", 8'(pwr_on[0]),        8'h0);

    // domain 1 to SLEEP while domain 0 sits in DEEP
    activity[1] = 1'b0; repeat (4) step();
    sleep_req[1] = 1'b1; step();
    sleep_req[1] = 1'b0; step();
    check("mixed_asleep", 8'(all_asleep), 8'h1);
    check("mixed_mode",   8'(power_mode), 8'hB);
    force_active = 1'b1; step();
    force_active = 1'b0; step();
    check("force_mode",   8'(power_mode), 8'h3);
    check("force_asleep", 8'(all_asleep), 8'h0);
    check("force_pwr_on", 8'(pwr_on),     8'h3);

    // asynchronous reset while domain 0 is in WAKE
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_mode",   8'(power_mode), 8'h0);
    check("async_rst_pwr_on", 8'(pwr_on),     8'h3);
    check("async_rst_clk_en", 8'(clk_en),     8'h3);
    step(); rst_n = 1'b1;

    // both domains SLEEP, then force_active
    activity = 2'b00; repeat (4) step();
    sleep_req = 2'b11; step();
    sleep_req = 2'b00; step();
    check("both_sleep_asleep", 8'(all_asleep), 8'h1);
    check("both_sleep_mode",   8'(power_mode), 8'hA);
    force_active = 1'b1; step();
    step();
    check("both_force_mode",   8'(power_mode), 8'h0);
    check("both_force_asleep", 8'(all_asleep), 8'h0);
    check("both_force_clk_en", 8'(clk_en),     8'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
